// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way, 64-set cache fill controller.
//   - address field widths (tag / set / word) and metadata bit positions
//   - block geometry and memory latency
//   - controller state encoding
//   - helpers: one-hot set decode and metadata packing
package cache_pkg;

  localparam int TAG_W           = 6;
  localparam int SET_W           = 6;
  localparam int WORD_W          = 3;
  localparam int META_W          = 8;
  localparam int META_LRU        = 7;
  localparam int META_VALID      = 6;
  localparam int NUM_SETS        = 64;
  localparam int WORDS_PER_BLOCK = 8;
  // Cycles from an address issue to its return strobe. The controller
  // counts returns instead of timing them, so only the environment uses it.
  localparam int MEM_LATENCY     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2
  } state_e;

  function automatic logic [NUM_SETS-1:0] set_onehot(input logic [SET_W-1:0] set_idx);
    logic [NUM_SETS-1:0] r_sel;
    r_sel          = '0;
    r_sel[set_idx] = 1'b1;
    return r_sel;
  endfunction

  // Freshly written metadata is always valid and most recently used (lru=0).
  function automatic logic [META_W-1:0] pack_meta(input logic [TAG_W-1:0] tag);
    logic [META_W-1:0] r_meta;
    r_meta              = '0;
    r_meta[TAG_W-1:0]   = tag;
    r_meta[META_VALID]  = 1'b1;
    r_meta[META_LRU]    = 1'b0;
    return r_meta;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Combinational tag compare and replacement choice for one set.
// Ports:
//   i_meta0, i_meta1 : way 0 / way 1 metadata {lru, valid, tag}
//   i_tag            : tag of the current request
//   o_match          : at least one valid way holds i_tag
//   o_hit_way        : matching way (way 0 wins when both match)
//   o_victim_way     : way to refill on a miss
module cache_victim_select
  import cache_pkg::*;
(
  input  logic [META_W-1:0] i_meta0,
  input  logic [META_W-1:0] i_meta1,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_match,
  output logic              o_hit_way,
  output logic              o_victim_way
);

  logic w_valid0;
  logic w_valid1;
  logic w_match0;
  logic w_match1;

  assign w_valid0 = i_meta0[META_VALID];
  assign w_valid1 = i_meta1[META_VALID];
  assign w_match0 = w_valid0 && (i_meta0[TAG_W-1:0] == i_tag);
  assign w_match1 = w_valid1 && (i_meta1[TAG_W-1:0] == i_tag);

  assign o_match   = w_match0 || w_match1;
  assign o_hit_way = !w_match0;

  // Invalid ways are filled first (way 0 before way 1). With both valid the
  // way marked lru=1 goes; a tie on the LRU bits falls back to way 0.
  always_comb begin
    o_victim_way = 1'b0;
    if (!w_valid0) begin
      o_victim_way = 1'b0;
    end else if (!w_valid1) begin
      o_victim_way = 1'b1;
    end else begin
      o_victim_way = i_meta1[META_LRU] && !i_meta0[META_LRU];
    end
  end

endmodule

// File: rtl/cache_fill_controller.sv
// Sequencing controller for a 2-way, 64-set cache.
// Hits are resolved in the request cycle; a miss stalls the pipeline while an
// 8-word block streams from pipelined main memory into the victim way, then
// the victim's metadata is written and the held request retries as a hit.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_req_valid/write   : pipeline access request / store flag
//   i_req_addr          : byte address {tag[15:10], set[9:4], offset[3:0]}
//   i_meta_out0/1       : metadata of the enabled set, per way
//   o_set_enable        : one-hot set select for both arrays
//   o_meta_write0/1     : metadata write strobe per way
//   o_meta_din          : metadata to write {lru, valid, tag}
//   o_data_write        : data-array word write strobe
//   o_data_way/word     : data-array way and word index
//   o_data_from_mem     : data write source, 1 = memory, 0 = store data
//   o_mem_en, o_mem_addr: memory read issue and its address
//   i_mem_data_valid    : memory return strobe
//   o_hit, o_stall      : hit indication, pipeline freeze
//   o_state             : current controller state (debug)
//
// Handshake: a request is presented with i_req_valid and held unchanged while
// o_stall is high; it is consumed in the first cycle o_stall is low.
module cache_fill_controller
  import cache_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  input  logic                i_req_write,
  input  logic [15:0]         i_req_addr,
  input  logic [META_W-1:0]   i_meta_out0,
  input  logic [META_W-1:0]   i_meta_out1,
  output logic [NUM_SETS-1:0] o_set_enable,
  output logic                o_meta_write0,
  output logic                o_meta_write1,
  output logic [META_W-1:0]   o_meta_din,
  output logic                o_data_write,
  output logic                o_data_way,
  output logic [WORD_W-1:0]   o_data_word,
  output logic                o_data_from_mem,
  output logic                o_mem_en,
  output logic [15:0]         o_mem_addr,
  input  logic                i_mem_data_valid,
  output logic                o_hit,
  output logic                o_stall,
  output logic [1:0]          o_state
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

  state_e            r_state;
  logic [TAG_W-1:0]  r_tag;
  logic [SET_W-1:0]  r_set;
  logic              r_victim;
  logic [WORD_W-1:0] r_issue_cnt;
  logic              r_issue_done;
  logic [WORD_W-1:0] r_recv_cnt;

  logic [TAG_W-1:0]  w_req_tag;
  logic [SET_W-1:0]  w_req_set;
  logic [WORD_W-1:0] w_req_word;
  logic              w_unused_byte;
  logic              w_match;
  logic              w_hit_way;
  logic              w_victim_way;
  logic              w_miss;
  logic              w_issue;

  assign w_req_tag     = i_req_addr[15:10];
  assign w_req_set     = i_req_addr[9:4];
  assign w_req_word    = i_req_addr[3:1];
  assign w_unused_byte = i_req_addr[0];

  cache_victim_select u_victim_select (
    .i_meta0      (i_meta_out0),
    .i_meta1      (i_meta_out1),
    .i_tag        (w_req_tag),
    .o_match      (w_match),
    .o_hit_way    (w_hit_way),
    .o_victim_way (w_victim_way)
  );

  assign w_miss  = (r_state == IDLE) && i_req_valid && !w_match;
  // Issue runs ahead of the returns; the done flag stops it after 8 addresses
  // because the 3-bit counter wraps back to 0 on the last one.
  assign w_issue = (r_state == FILL) && !r_issue_done;

  assign o_state = r_state;

  // Kept apart from the other decode: the metadata array answers the set
  // select combinationally, so mixing it with the hit logic would form a loop.
  assign o_set_enable = i_rst ? '0 :
                        (r_state == IDLE) ? set_onehot(w_req_set) : set_onehot(r_set);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_set        <= '0;
      r_victim     <= 1'b0;
      r_issue_cnt  <= '0;
      r_issue_done <= 1'b0;
      r_recv_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_tag        <= w_req_tag;
            r_set        <= w_req_set;
            r_victim     <= w_victim_way;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_recv_cnt   <= '0;
            r_state      <= FILL;
          end
        end
        FILL: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_issue_cnt == LAST_WORD) begin
              r_issue_done <= 1'b1;
            end
          end
          if (i_mem_data_valid) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
            if (r_recv_cnt == LAST_WORD) begin
              r_state <= META;
            end
          end
        end
        META: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_meta_write0   = 1'b0;
    o_meta_write1   = 1'b0;
    o_meta_din      = '0;
    o_data_write    = 1'b0;
    o_data_way      = 1'b0;
    o_data_word     = '0;
    o_data_from_mem = 1'b0;
    o_mem_en        = 1'b0;
    o_mem_addr      = '0;
    o_hit           = 1'b0;
    o_stall         = 1'b0;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            if (w_match) begin
              // The array itself clears this way's LRU bit and sets the other's.
              o_hit         = 1'b1;
              o_data_way    = w_hit_way;
              o_data_word   = w_req_word;
              o_meta_write0 = !w_hit_way;
              o_meta_write1 = w_hit_way;
              o_meta_din    = pack_meta(w_req_tag);
              o_data_write  = i_req_write;
            end else begin
              o_stall = 1'b1;
            end
          end
        end
        FILL: begin
          o_stall  = 1'b1;
          o_mem_en = w_issue;
          if (w_issue) begin
            o_mem_addr = {r_tag, r_set, r_issue_cnt, 1'b0};
          end
          if (i_mem_data_valid) begin
            o_data_write    = 1'b1;
            o_data_from_mem = 1'b1;
            o_data_way      = r_victim;
            o_data_word     = r_recv_cnt;
          end
        end
        META: begin
          o_stall       = 1'b1;
          o_meta_write0 = !r_victim;
          o_meta_write1 = r_victim;
          o_meta_din    = pack_meta(r_tag);
        end
        default: begin
          o_stall = 1'b0;
        end
      endcase
    end
  end

endmodule
